misr_sig_ctrl: RTL
==================

# misr_sig_ctrl

Parametrised multiple-input signature register with a built-in compaction controller and golden-signature comparator. It compacts a programmable number of parallel response vectors from a circuit under test into a WIDTH-bit signature using a configurable feedback polynomial, then reports pass/fail against a supplied golden value. It is the BIST response-analysis block that sits after the pattern generator and CUT in the self-test datapath, and it generalises the fixed 3-input, 21-stage signature register.

## Interface
- WIDTH, 21: signature register length in bits (≥ 2).
- NIN, 3: number of parallel response inputs (1 ≤ NIN ≤ WIDTH).
- POLY, 21'h000005: feedback tap mask; bit i set means feedback enters stage i (default x^21+x^2+1).
- SEED, 0: signature value loaded on start.
- CNT_W, 16: width of pattern counter.

- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin a compaction run (sampled in IDLE or DONE only).
- n_patterns  in  CNT_W  number of vectors to compact; sampled with start.
- din  in  NIN  CUT response vector.
- din_valid  in  1  din is accepted this cycle (RUN only).
- golden  in  WIDTH  expected signature; sampled on the cycle the run ends.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  signature equals golden; meaningful only while done=1.
- sig  out  WIDTH  current signature register contents.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; sig=SEED, count=0, busy=0, done=0, pass=0.
- IDLE/DONE + start=1: sig←SEED, count←n_patterns, done←0, pass←0; next state RUN, or DONE directly if n_patterns=0 (then pass←(SEED==golden)).
- RUN + din_valid=1: one compaction step, count←count−1. If count was 1: next state DONE, pass←(next sig == golden), golden sampled this cycle.
- RUN + din_valid=0: sig and count hold.
- start in RUN ignored; din_valid outside RUN ignored (sig holds).
- Compaction step (internal-XOR form), fb = sig[WIDTH−1], d_i = din[i] for i<NIN else 0:
  - sig'[0] = (POLY[0] & fb) ^ d_0
  - sig'[i] = sig[i−1] ^ (POLY[i] & fb) ^ d_i, for 1 ≤ i < WIDTH.
- All arithmetic is XOR/modulo-2; count is unsigned, never wraps (stops at 0 in DONE).
- DONE holds sig, done=1, pass until next start or RST.

## Timing
- start sampled at edge k; RUN active from k+1; first vector can be accepted at edge k+1.
- Last vector accepted at edge m: done=1, pass valid, sig final from edge m (registered, visible cycle after m's edge; no extra latency).
- n_patterns=0: done=1 the cycle after start; sig=SEED.
- Throughput: one vector per cycle with din_valid held high; a run of N vectors with continuous valid completes N cycles after start.
- start with done=1 clears done/pass at the same edge it reloads SEED.
- RST asserted at any time (including mid-RUN) clears all state asynchronously; release resumes in IDLE; no partial signature retained.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, NIN=1, POLY=4'b0011, SEED=4'b0001, din=0, n_patterns=15, valid continuous -> sig cycles through 15 distinct nonzero values, returns to 4'b0001, done=1 after 15 accepted vectors, pass=1 with golden=4'b0001.
- Same parameters, SEED=0, n_patterns=2, din=1 then din=0 -> sig=4'b0001 after first, 4'b0010 after second; golden=4'b0011 -> pass=0, done=1.
- Defaults, n_patterns=4, din_valid toggled 1,0,1,0,1,0,1 -> exactly 4 steps, sig unchanged on invalid cycles, busy=1 throughout, done rises after 4th valid.
- Defaults, n_patterns=0, start with golden=0 -> done=1 next cycle, sig=0, pass=1; golden=1 -> pass=0.
- Defaults, start n_patterns=100, assert RST after 10 vectors -> sig=SEED, busy=0, done=0, pass=0 immediately; start ignored while RUN in a separate run (count unaffected).
- Single-bit error injection: default params, golden from fault-free 50-vector run; flip one din bit in vector 20 -> pass=0.

Source files
------------

// File: rtl/misr_sig_ctrl.sv
// Multiple-input signature register with compaction run controller and
// golden-signature comparator for BIST response analysis.
module misr_sig_ctrl #(
  parameter int               WIDTH = 21,
  parameter int               NIN   = 3,
  parameter logic [WIDTH-1:0] POLY  = 21'h000005,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}},
  parameter int               CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] n_patterns,
  input  logic [NIN-1:0]   din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Internal-XOR compaction: shift up, fold the MSB back through the tap mask
  // and absorb the response vector into the low stages.
  function automatic logic [WIDTH-1:0] compact_step(
    input logic [WIDTH-1:0] s,
    input logic [NIN-1:0]   d
  );
    logic [WIDTH-1:0] v_d;
    logic [WIDTH-1:0] v_fb;
    v_d          = {WIDTH{1'b0}};
    v_d[NIN-1:0] = d;
    v_fb         = POLY & {WIDTH{s[WIDTH-1]}};
    return {s[WIDTH-2:0], 1'b0} ^ v_fb ^ v_d;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [WIDTH-1:0] w_step;

  assign w_step = compact_step(r_sig, din);

  // Run controller: state, signature, pattern counter and registered flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_count <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sig   <= SEED;
            r_count <= n_patterns;
            // An empty run completes immediately against the seed value.
            if (n_patterns == CNT_ZERO) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (SEED == golden);
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end else begin
            r_state <= r_state;
            r_sig   <= r_sig;
            r_count <= r_count;
            r_busy  <= r_busy;
            r_done  <= r_done;
            r_pass  <= r_pass;
          end
        end
        S_RUN: begin
          if (din_valid) begin
            r_sig   <= w_step;
            r_count <= r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_step == golden);
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end else begin
            r_state <= r_state;
            r_sig   <= r_sig;
            r_count <= r_count;
            r_busy  <= r_busy;
            r_done  <= r_done;
            r_pass  <= r_pass;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sig   <= SEED;
          r_count <= CNT_ZERO;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;
  assign sig  = r_sig;

endmodule
